mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the fetch stage (read-only) and the MEM stage (read/write).
//  Sits between the pipeline and the memory macro; drives per-requester stall/ack signals that gate PC and pipe-register updates.
//  Data side has priority (older instruction); a streak counter bounds fetch starvation.
// PARAMETERS
//  ADDR_W        9   byte address width (matches DM_ADDRESS)
//  DATA_W        32  data width
//  RD_LAT        1   memory read latency in cycles, >=1; m_rdata valid RD_LAT cycles after the m_req cycle
//  MAX_D_STREAK  4   consecutive data grants allowed while fetch waits, >=1
// PORTS
//  clk       in   1       clock
//  reset     in   1       synchronous, active-high reset
//  i_req     in   1       fetch read request; held with i_addr until i_ack
//  i_addr    in   ADDR_W  fetch address
//  i_flush   in   1       branch/jump flush (PcSel); kills an in-flight fetch
//  i_ack     out  1       one-cycle pulse: i_rdata valid
//  i_rdata   out  DATA_W  fetched instruction
//  i_stall   out  1       i_req & ~i_ack
//  d_req     in   1       data request; held with d_we/d_addr/d_wdata/d_funct3 until d_ack
//  d_we      in   1       1=store, 0=load
//  d_addr    in   ADDR_W  data address
//  d_wdata   in   DATA_W  store data
//  d_funct3  in   3       access size/sign, passed through to memory
//  d_ack     out  1       one-cycle pulse: load data valid / store done
//  d_rdata   out  DATA_W  load data
//  d_stall   out  1       d_req & ~d_ack
//  m_req     out  1       memory access strobe, one cycle per access
//  m_we      out  1       memory write enable
//  m_addr    out  ADDR_W  memory address
//  m_wdata   out  DATA_W  memory write data
//  m_funct3  out  3       size/sign (3'b010 for fetches)
//  m_rdata   in   DATA_W  memory read data
//  busy      out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, streak=0, owner=NONE, kill=0; every output 0 (rdata regs cleared).
//  FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All m_* and ack/rdata outputs are registered.
//  IDLE: grant D if d_req & ~(i_req & streak==MAX_D_STREAK); else grant I if i_req; else stay.
//    On grant, latch owner and request fields into m_* regs; go to ISSUE.
//  ISSUE (1 cycle): m_req=1, m_* stable. Store -> DONE. Load or fetch -> WAIT, wcnt=RD_LAT.
//  WAIT: decrement wcnt; on wcnt==1, capture m_rdata into owner's rdata reg and go to DONE.
//  DONE (1 cycle): owner's ack=1 (suppressed if kill); then go to IDLE; all m_* return to 0.
//  Latency, grant cycle g (IDLE): load/fetch ack in cycle g+RD_LAT+2; store ack in g+2.
//  Throughput: one access per RD_LAT+3 cycles (store 3). No new grant in ISSUE/WAIT/DONE.
//  Requester protocol: drop or change the request at the edge after ack. IDLE samples only after DONE, so an acked request is never re-granted.
//  Streak: D grant with i_req=1 -> streak+1, saturating at MAX_D_STREAK; D grant with i_req=0 -> 0; I grant -> 0.
//  Simultaneous i_req & d_req with streak<MAX: D wins. At streak==MAX: I wins.
//  i_flush while owner=I in ISSUE/WAIT/DONE sets kill: memory access completes, i_ack suppressed, i_rdata not updated.
//    kill clears on entering IDLE. i_flush in IDLE only has effect if i_req is also 1 (it is granted normally).
//  i_flush never affects a data access.
//  Reset mid-access: abort immediately to reset state; any late m_rdata is ignored; no ack is issued.
//  Stores never enter WAIT. d_rdata holds its value until the next load completes; i_rdata holds until the next unkilled fetch.
//  Width: m_addr = latched address, no truncation. Alignment is the requester's responsibility.
// STRUCTURE
//  Shared package (Pipe_Buf_Reg_PKG or sibling): typedef enum arb_state_t {IDLE,ISSUE,WAIT,DONE};
//    typedef enum arb_owner_t {OWN_NONE,OWN_I,OWN_D}; localparam FUNCT3_WORD=3'b010.
//  Single module; a small wait-counter is inline. No sub-module needed.
// TESTING
//  1 Lone fetch, RD_LAT=1: i_req=1, i_addr=9'h004, mem[4]=32'h00500093 -> m_req in g+1; i_ack and i_rdata=32'h00500093 in g+3; i_stall=1 for g..g+2.
//  2 Store then load: d_we=1, d_addr=9'h010, d_wdata=32'hDEADBEEF -> d_ack in g+2. Then load from 9'h010 -> d_rdata=32'hDEADBEEF.
//  3 Contention: i_req and d_req held high, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; streak observed 1..4 then 0.
//  4 Flush: fetch granted, i_flush=1 in WAIT -> no i_ack, i_rdata unchanged, busy drops after DONE; next fetch from new PC acks normally.
//  5 Reset mid-access: reset=1 during WAIT of a load -> next cycle all outputs 0, state IDLE; m_rdata driven afterwards produces no d_ack.
//  6 RD_LAT=3 sweep: load ack exactly g+5; m_req never asserted twice within one access; no grant while busy=1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    // Fetches are always full-word accesses
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data requests onto one single-port memory
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_funct3,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int WCNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam int STRK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(RD_LAT);
    localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(MAX_D_STREAK);

    arb_state_t        state;
    arb_owner_t        owner;
    logic              kill;
    logic [WCNT_W-1:0] wcnt;
    logic [STRK_W-1:0] streak;

    logic starve_i;
    logic grant_d;
    logic grant_i;
    logic kill_now;

    // Data side wins unless fetch has already waited through a full streak of data grants
    assign starve_i = i_req & (streak == STRK_MAX);
    assign grant_d  = d_req & ~starve_i;
    assign grant_i  = i_req & ~grant_d;
    // A flush arriving in the capture cycle must also suppress the fetch result
    assign kill_now = kill | (i_flush & (owner == OWN_I));

    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;
    assign busy    = (state != IDLE);

    // Arbitration FSM: latches a request, strobes memory once, waits, then acks the owner
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            kill     <= 1'b0;
            wcnt     <= '0;
            streak   <= '0;
            i_ack    <= 1'b0;
            i_rdata  <= '0;
            d_ack    <= 1'b0;
            d_rdata  <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_funct3 <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            m_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner    <= OWN_D;
                        m_req    <= 1'b1;
                        m_we     <= d_we;
                        m_addr   <= d_addr;
                        m_wdata  <= d_wdata;
                        m_funct3 <= d_funct3;
                        if (!i_req) begin
                            streak <= '0;
                        end else if (streak != STRK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                        state <= ISSUE;
                    end else if (grant_i) begin
                        owner    <= OWN_I;
                        m_req    <= 1'b1;
                        m_we     <= 1'b0;
                        m_addr   <= i_addr;
                        m_wdata  <= '0;
                        m_funct3 <= FUNCT3_WORD;
                        streak   <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    kill <= kill_now;
                    if (m_we) begin
                        d_ack <= 1'b1;
                        state <= DONE;
                    end else begin
                        wcnt  <= WCNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    kill <= kill_now;
                    wcnt <= wcnt - 1'b1;
                    if (wcnt == 1) begin
                        state <= DONE;
                        if (owner == OWN_D) begin
                            d_rdata <= m_rdata;
                            d_ack   <= 1'b1;
                        end else if (!kill_now) begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    kill     <= 1'b0;
                    owner    <= OWN_NONE;
                    m_we     <= 1'b0;
                    m_addr   <= '0;
                    m_wdata  <= '0;
                    m_funct3 <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at RD_LAT 1 and 3
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, i_flush = 1'b0;
    logic [8:0]  i_addr = '0;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [8:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_funct3 = '0;
    logic        mem_init = 1'b0;
    logic        ovr = 1'b0;
    logic        use_b = 1'b0;

    logic        i_ack_a, i_stall_a, d_ack_a, d_stall_a, m_req_a, m_we_a, busy_a;
    logic [31:0] i_rdata_a, d_rdata_a, m_wdata_a, m_rdata_a, pipe_a;
    logic [8:0]  m_addr_a;
    logic [2:0]  m_funct3_a;
    logic        i_ack_b, i_stall_b, d_ack_b, d_stall_b, m_req_b, m_we_b, busy_b;
    logic [31:0] i_rdata_b, d_rdata_b, m_wdata_b, m_rdata_b;
    logic [31:0] pipe_b [3];
    logic [8:0]  m_addr_b;
    logic [2:0]  m_funct3_b;

    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];
    logic [31:0] shadow [512];
    exp_t        sb_q [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_i;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1), .MAX_D_STREAK(4)) dut_a (
        .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_ack(i_ack_a), .i_rdata(i_rdata_a), .i_stall(i_stall_a),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_ack(d_ack_a), .d_rdata(d_rdata_a), .d_stall(d_stall_a),
        .m_req(m_req_a), .m_we(m_we_a), .m_addr(m_addr_a), .m_wdata(m_wdata_a),
        .m_funct3(m_funct3_a), .m_rdata(m_rdata_a), .busy(busy_a)
    );

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3), .MAX_D_STREAK(4)) dut_b (
        .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_ack(i_ack_b), .i_rdata(i_rdata_b), .i_stall(i_stall_b),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_ack(d_ack_b), .d_rdata(d_rdata_b), .d_stall(d_stall_b),
        .m_req(m_req_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b),
        .m_funct3(m_funct3_b), .m_rdata(m_rdata_b), .busy(busy_b)
    );

    function automatic logic [31:0] init_word(input logic [8:0] a);
        return (a == 9'h004) ? 32'h00500093 : (32'hA500_0000 | {23'd0, a});
    endfunction

    // Memory macro models: write on strobe, read data appears RD_LAT cycles after the strobe
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) begin
                mem_a[i] <= init_word(9'(i));
                mem_b[i] <= init_word(9'(i));
            end
        end else begin
            if (m_req_a && m_we_a) mem_a[m_addr_a] <= m_wdata_a;
            if (m_req_b && m_we_b) mem_b[m_addr_b] <= m_wdata_b;
        end
        pipe_a    <= (m_req_a && !m_we_a) ? mem_a[m_addr_a] : 32'hBAD0_0001;
        pipe_b[0] <= (m_req_b && !m_we_b) ? mem_b[m_addr_b] : 32'hBAD0_0003;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign m_rdata_a = ovr ? 32'h1234_5678 : pipe_a;
    assign m_rdata_b = ovr ? 32'h1234_5678 : pipe_b[2];

    logic        s_i_ack, s_i_stall, s_d_ack, s_d_stall, s_m_req, s_m_we, s_busy;
    logic [31:0] s_i_rdata, s_d_rdata, s_m_wdata;
    logic [8:0]  s_m_addr;
    logic [2:0]  s_m_funct3;
    assign s_i_ack    = use_b ? i_ack_b    : i_ack_a;
    assign s_i_stall  = use_b ? i_stall_b  : i_stall_a;
    assign s_i_rdata  = use_b ? i_rdata_b  : i_rdata_a;
    assign s_d_ack    = use_b ? d_ack_b    : d_ack_a;
    assign s_d_stall  = use_b ? d_stall_b  : d_stall_a;
    assign s_d_rdata  = use_b ? d_rdata_b  : d_rdata_a;
    assign s_m_req    = use_b ? m_req_b    : m_req_a;
    assign s_m_we     = use_b ? m_we_b     : m_we_a;
    assign s_m_addr   = use_b ? m_addr_b   : m_addr_a;
    assign s_m_wdata  = use_b ? m_wdata_b  : m_wdata_a;
    assign s_m_funct3 = use_b ? m_funct3_b : m_funct3_a;
    assign s_busy     = use_b ? busy_b     : busy_a;

    task automatic test_reset();
        reset = 1'b1;
        mem_init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({i_ack_a, i_rdata_a, i_stall_a, d_ack_a, d_rdata_a, d_stall_a, m_req_a, m_we_a,
             m_addr_a, m_wdata_a, m_funct3_a, busy_a} !== '0)
            $display("FAIL reset_a: outputs not all zero (m_req=%b busy=%b m_addr=%h)", m_req_a, busy_a, m_addr_a);
        else n_pass++;
        n_checks++;
        if ({i_ack_b, i_rdata_b, i_stall_b, d_ack_b, d_rdata_b, d_stall_b, m_req_b, m_we_b,
             m_addr_b, m_wdata_b, m_funct3_b, busy_b} !== '0)
            $display("FAIL reset_b: outputs not all zero (m_req=%b busy=%b m_addr=%h)", m_req_b, busy_b, m_addr_b);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_access(input bit fetch, input bit we, input logic [8:0] addr,
                             input logic [31:0] wdata, input logic [2:0] f3, input int lat,
                             input string name);
        exp_t        e;
        exp_t        ge;
        int          g, nreq, req_cyc, ack_cyc;
        bit          seen, stall_ok, stall_low;
        logic [31:0] got, mwd;
        logic [8:0]  mad;
        logic        mwe;
        logic [2:0]  mf3, ef3;
        nreq = 0; req_cyc = -1; ack_cyc = -1; seen = 0; stall_ok = 1; stall_low = 0;
        got = '0; mwd = '0; mad = '0; mwe = 1'b0; mf3 = '0;
        ef3 = fetch ? 3'b010 : f3;
        @(posedge clk);
        #1;
        if (fetch) begin
            i_req = 1'b1; i_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_funct3 = f3;
        end
        g = cyc;
        e.data = (fetch || !we) ? shadow[addr] : 32'h0;
        e.cyc  = g + lat;
        sb_q.push_back(e);
        if (!fetch && we) shadow[addr] = wdata;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (s_m_req) begin
                nreq++;
                if (nreq == 1) begin
                    req_cyc = cyc; mad = s_m_addr; mwe = s_m_we; mf3 = s_m_funct3; mwd = s_m_wdata;
                end
            end
            if (fetch ? s_i_ack : s_d_ack) begin
                seen = 1; ack_cyc = cyc;
                got = fetch ? s_i_rdata : s_d_rdata;
                stall_low = !(fetch ? s_i_stall : s_d_stall);
            end else if (!(fetch ? s_i_stall : s_d_stall)) begin
                stall_ok = 0;
            end
        end
        @(posedge clk);
        #1;
        if (fetch) i_req = 1'b0; else d_req = 1'b0;
        ge = sb_q.pop_front();
        n_checks++;
        if (!seen || ack_cyc != ge.cyc)
            $display("FAIL %s_latency: ack seen=%0d at g+%0d, required g+%0d", name, seen, ack_cyc - g, ge.cyc - g);
        else n_pass++;
        if (fetch || !we) begin
            n_checks++;
            if (got !== ge.data) $display("FAIL %s_data: got %h, required %h", name, got, ge.data);
            else n_pass++;
        end
        n_checks++;
        if (nreq != 1 || req_cyc != g + 1)
            $display("FAIL %s_mreq: %0d strobes, first at g+%0d, required 1 at g+1", name, nreq, req_cyc - g);
        else n_pass++;
        n_checks++;
        if (mad !== addr || mwe !== we || mf3 !== ef3 || (we && mwd !== wdata))
            $display("FAIL %s_fields: addr=%h we=%b f3=%b wdata=%h, required addr=%h we=%b f3=%b wdata=%h",
                     name, mad, mwe, mf3, mwd, addr, we, ef3, wdata);
        else n_pass++;
        n_checks++;
        if (!(stall_ok && stall_low))
            $display("FAIL %s_stall: high-before-ack=%0d low-at-ack=%0d, required 1 and 1", name, stall_ok, stall_low);
        else n_pass++;
    endtask

    task automatic test_lone_fetch();
        use_b = 1'b0;
        do_access(1'b1, 1'b0, 9'h004, 32'h0, 3'b000, 3, "fetch_lone");
    endtask

    task automatic test_store_load();
        use_b = 1'b0;
        do_access(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 2, "store");
        n_checks++;
        if (mem_a[16] !== 32'hDEADBEEF) $display("FAIL store_mem: mem[0x10]=%h, required deadbeef", mem_a[16]);
        else n_pass++;
        do_access(1'b0, 1'b0, 9'h010, 32'h0, 3'b100, 3, "load");
    endtask

    task automatic test_contention();
        bit ord_q [$];
        bit exp_i, got_i;
        int popped;
        use_b = 1'b0;
        popped = 0;
        ord_q = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        @(posedge clk);
        #1;
        i_req = 1'b1; i_addr = 9'h020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h040; d_funct3 = 3'b010;
        for (int k = 0; k < 200 && popped < 10; k++) begin
            @(negedge clk);
            if (m_req_a) begin
                exp_i = ord_q.pop_front();
                got_i = (m_addr_a == 9'h020);
                n_checks++;
                if (got_i !== exp_i)
                    $display("FAIL grant_order[%0d]: got fetch=%b, required fetch=%b", popped, got_i, exp_i);
                else n_pass++;
                popped++;
            end
        end
        if (popped < 10) begin
            n_checks++;
            $display("FAIL grant_order_timeout: %0d grants seen, required 10", popped);
        end
        @(posedge clk);
        #1;
        i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy_a) break;
        end
        last_i = shadow[9'h020];
        n_checks++;
        if (i_rdata_a !== last_i || d_rdata_a !== shadow[9'h040])
            $display("FAIL contention_rdata: i=%h d=%h, required i=%h d=%h", i_rdata_a, d_rdata_a, last_i, shadow[9'h040]);
        else n_pass++;
    endtask

    task automatic test_flush();
        exp_t        e;
        exp_t        ge;
        int          g, ack_cyc;
        bit          early, busy_ok, hold_ok;
        logic [31:0] got;
        use_b = 1'b0;
        early = 0; busy_ok = 0; hold_ok = 0; ack_cyc = -1; got = '0;
        @(posedge clk);
        #1;
        i_req = 1'b1; i_addr = 9'h008;
        g = cyc;
        for (int k = 0; k < 20 && ack_cyc < 0; k++) begin
            @(negedge clk);
            if (cyc == g + 4) busy_ok = !busy_a;
            if (cyc == g + 5) hold_ok = (i_rdata_a === last_i);
            if (i_ack_a) begin
                if (cyc < g + 7) early = 1;
                else begin
                    ack_cyc = cyc; got = i_rdata_a;
                end
            end
            @(posedge clk);
            #1;
            if (cyc == g + 2) begin
                i_flush = 1'b1; i_addr = 9'h00C;
                e.data = shadow[9'h00C]; e.cyc = g + 7;
                sb_q.push_back(e);
            end else begin
                i_flush = 1'b0;
            end
            if (ack_cyc >= 0) i_req = 1'b0;
        end
        i_req = 1'b0; i_flush = 1'b0;
        ge = sb_q.pop_front();
        n_checks++;
        if (early) $display("FAIL flush_no_ack: killed fetch acked, required no ack");
        else n_pass++;
        n_checks++;
        if (!hold_ok || !busy_ok)
            $display("FAIL flush_hold: rdata-held=%0d idle-after-done=%0d, required 1 and 1", hold_ok, busy_ok);
        else n_pass++;
        n_checks++;
        if (ack_cyc != ge.cyc || got !== ge.data)
            $display("FAIL flush_refetch: ack at g+%0d data %h, required g+%0d data %h", ack_cyc - g, got, ge.cyc - g, ge.data);
        else n_pass++;
        last_i = ge.data;
    endtask

    task automatic test_reset_mid_access();
        bit late_ack;
        use_b = 1'b0;
        late_ack = 0;
        @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h010; d_funct3 = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; d_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({i_ack_a, i_rdata_a, i_stall_a, d_ack_a, d_rdata_a, d_stall_a, m_req_a, m_we_a,
             m_addr_a, m_wdata_a, m_funct3_a, busy_a} !== '0)
            $display("FAIL reset_mid: outputs not zero (d_ack=%b d_rdata=%h busy=%b m_addr=%h)", d_ack_a, d_rdata_a, busy_a, m_addr_a);
        else n_pass++;
        ovr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (d_ack_a || d_rdata_a !== 32'h0 || busy_a) late_ack = 1;
        end
        ovr = 1'b0;
        n_checks++;
        if (late_ack) $display("FAIL reset_late_rdata: ack/busy/rdata after reset, required none");
        else n_pass++;
    endtask

    task automatic test_rd_lat3();
        use_b = 1'b1;
        do_access(1'b0, 1'b1, 9'h030, 32'hCAFEF00D, 3'b010, 2, "lat3_store");
        do_access(1'b0, 1'b0, 9'h030, 32'h0, 3'b010, 5, "lat3_load");
        do_access(1'b1, 1'b0, 9'h004, 32'h0, 3'b000, 5, "lat3_fetch");
        use_b = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) shadow[i] = init_word(9'(i));
        last_i = '0;
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_contention();
        test_flush();
        test_reset_mid_access();
        test_rd_lat3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
